// File: rtl/seq_pkg.sv
// Shared types and helpers for the ALU -> UART sequencer.
// Byte count follows SEQ_HEX_ASCII_EN (3 ASCII bytes when defined, 1 raw byte otherwise).
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    TX_REQ  = 3'd4,
    TX_ACK  = 3'd5,
    TX_WAIT = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam logic [7:0] CR = 8'h0D;

`ifdef SEQ_HEX_ASCII_EN
  localparam int N_BYTES = 3;
  localparam int IDX_W   = 2;
`else
  localparam int N_BYTES = 1;
  localparam int IDX_W   = 1;
`endif

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Uppercase hex digit: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/seq_tx_handshake.sv
// UART enable/busy handshake for one byte at a time, with a timeout on the
// busy acknowledge. ack_done and timeout are single-cycle decodes.
//
// state   | meaning
// TX_REQ  | ready; sends tx_byte once go=1 and the UART is not busy
// TX_ACK  | request issued, waiting for uartbusy to rise (timed)
// TX_WAIT | UART accepted the byte, waiting for uartbusy to fall
module seq_tx_handshake
  import seq_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       go,
  input  logic [7:0] tx_byte,
  input  logic       uartbusy,
  output logic       uart_tx_en,
  output logic [7:0] uart_tx_data,
  output logic       ack_done,
  output logic       timeout
);

  localparam int TMR_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  state_t            phase, phase_nxt;
  logic [TMR_W-1:0]  tmr;
  logic              send;

  always_ff @(posedge clk) begin
    if (!reset_n) phase <= TX_REQ;
    else          phase <= phase_nxt;
  end

  always_comb begin
    phase_nxt = phase;
    case (phase)
      TX_REQ:  if (send)                phase_nxt = TX_ACK;
      TX_ACK:  if (uartbusy)            phase_nxt = TX_WAIT;
               else if (tmr == '0)      phase_nxt = TX_REQ;
      TX_WAIT: if (!uartbusy)           phase_nxt = TX_REQ;
      default:                          phase_nxt = TX_REQ;
    endcase
  end

  always_comb begin
    send     = (phase == TX_REQ) && go && !uartbusy;
    ack_done = (phase == TX_WAIT) && !uartbusy;
    timeout  = (phase == TX_ACK) && !uartbusy && (tmr == '0);
  end

  // Timer reloads on every request so each byte gets the full window.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      uart_tx_en   <= 1'b0;
      uart_tx_data <= 8'h00;
      tmr          <= '0;
    end else begin
      uart_tx_en <= send;
      if (send) begin
        uart_tx_data <= tx_byte;
        tmr          <= TMR_W'(BUSY_TIMEOUT - 1);
      end else if (phase == TX_ACK && tmr != '0) begin
        tmr <= tmr - TMR_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_uart_sequencer.sv
// Single-shot latch -> ALU -> UART sequencer replacing push-button strobes.
// Build option SEQ_HEX_ASCII_EN: send result as two ASCII hex digits plus CR.
//
// state   | meaning
// IDLE    | waiting for start; operands captured and validated on start
// LOAD_A  | present operand A, strobe save_a_n
// LOAD_B  | present operand B, strobe save_b_n
// COMPUTE | wait ALU_LAT cycles, then capture alu_result
// TX_REQ  | bytes handed to seq_tx_handshake (it walks REQ/ACK/WAIT)
// DONE    | one-cycle completion
module alu_uart_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int ALU_LAT      = 2,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [3:0]        op_sel,
  input  logic [7:0]        alu_result,
  input  logic              uartbusy,
  output logic [DATA_W-1:0] data_bus,
  output logic              save_a_n,
  output logic              save_b_n,
  output logic [3:0]        ena,
  output logic              uart_tx_en,
  output logic [7:0]        uart_tx_data,
  output logic              seq_busy,
  output logic              done,
  output logic              err
);

  localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] a_q, b_q;
  logic [3:0]        op_q;
  logic [7:0]        res_q;
  logic [LAT_W-1:0]  lat_cnt;
  logic [IDX_W-1:0]  byte_idx;
  logic [7:0]        tx_byte;
  logic              last_byte, tx_go, hs_ack_done, hs_timeout;

  logic [DATA_W-1:0] data_bus_d;
  logic              save_a_n_d, save_b_n_d, seq_busy_d, done_d;
  logic [3:0]        ena_d;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && is_onehot4(op_sel)) state_nxt = LOAD_A;
      LOAD_A:  state_nxt = LOAD_B;
      LOAD_B:  state_nxt = COMPUTE;
      COMPUTE: if (lat_cnt == '0) state_nxt = TX_REQ;
      TX_REQ:  if (hs_timeout)                    state_nxt = IDLE;
               else if (hs_ack_done && last_byte) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes follow the state by one register stage; busy/done track it exactly.
  always_comb begin
    data_bus_d = data_bus;
    save_a_n_d = 1'b1;
    save_b_n_d = 1'b1;
    ena_d      = (state == IDLE) ? 4'h0 : op_q;
    case (state)
      LOAD_A: begin
        data_bus_d = a_q;
        save_a_n_d = 1'b0;
      end
      LOAD_B: begin
        data_bus_d = b_q;
        save_b_n_d = 1'b0;
      end
      default: ;
    endcase
    seq_busy_d = (state_nxt != IDLE);
    done_d     = (state_nxt == DONE);
  end

`ifdef SEQ_HEX_ASCII_EN
  always_comb begin
    case (byte_idx)
      2'd0:    tx_byte = nib2ascii(res_q[7:4]);
      2'd1:    tx_byte = nib2ascii(res_q[3:0]);
      default: tx_byte = CR;
    endcase
  end
`else
  assign tx_byte = res_q;
`endif

  assign last_byte = (byte_idx == IDX_W'(N_BYTES - 1));
  assign tx_go     = (state == TX_REQ);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 4'h0;
      res_q    <= 8'h00;
      lat_cnt  <= '0;
      byte_idx <= '0;
      err      <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_q  <= op_a;
        b_q  <= op_b;
        op_q <= op_sel;
        err  <= !is_onehot4(op_sel);
      end else if (state == TX_REQ && hs_timeout) begin
        err <= 1'b1;
      end

      if (state == LOAD_B)
        lat_cnt <= LAT_W'(ALU_LAT - 1);
      else if (state == COMPUTE && lat_cnt != '0)
        lat_cnt <= lat_cnt - LAT_W'(1);

      if (state == COMPUTE && lat_cnt == '0) begin
        res_q    <= alu_result;
        byte_idx <= '0;
      end else if (state == TX_REQ && hs_ack_done) begin
        byte_idx <= byte_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_bus <= '0;
      save_a_n <= 1'b1;
      save_b_n <= 1'b1;
      ena      <= 4'h0;
      seq_busy <= 1'b0;
      done     <= 1'b0;
    end else begin
      data_bus <= data_bus_d;
      save_a_n <= save_a_n_d;
      save_b_n <= save_b_n_d;
      ena      <= ena_d;
      seq_busy <= seq_busy_d;
      done     <= done_d;
    end
  end

  seq_tx_handshake #(
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) u_tx (
    .clk          (clk),
    .reset_n      (reset_n),
    .go           (tx_go),
    .tx_byte      (tx_byte),
    .uartbusy     (uartbusy),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .ack_done     (hs_ack_done),
    .timeout      (hs_timeout)
  );

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Self-checking bench for alu_uart_sequencer: behavioural latch/ALU and UART
// models, a vector table, randomized operations and directed corner cases.
module tb_alu_uart_sequencer;

  localparam int ALU_LAT      = 2;
  localparam int BUSY_TIMEOUT = 1024;

  logic       clk, reset_n, start;
  logic [3:0] op_a, op_b, op_sel;
  logic [7:0] alu_result;
  logic       uartbusy;
  logic [3:0] data_bus, ena;
  logic       save_a_n, save_b_n, uart_tx_en, seq_busy, done, err;
  logic [7:0] uart_tx_data;

  alu_uart_sequencer #(
    .DATA_W(4), .ALU_LAT(ALU_LAT), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_a(op_a), .op_b(op_b),
    .op_sel(op_sel), .alu_result(alu_result), .uartbusy(uartbusy),
    .data_bus(data_bus), .save_a_n(save_a_n), .save_b_n(save_b_n), .ena(ena),
    .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data), .seq_busy(seq_busy),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU: add, subtract, multiply, concatenate.
  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    case (op)
      4'b0001: return {4'h0, a} + {4'h0, b};
      4'b0010: return {4'h0, a} - {4'h0, b};
      4'b0100: return {4'h0, a} * {4'h0, b};
      4'b1000: return {a, b};
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0] exp_q[$];
  string hx = "0123456789ABCDEF";

  task automatic build_exp(input logic [7:0] r);
    exp_q.delete();
`ifdef SEQ_HEX_ASCII_EN
    exp_q.push_back(hx[int'(r[7:4])]);
    exp_q.push_back(hx[int'(r[3:0])]);
    exp_q.push_back(8'h0D);
`else
    exp_q.push_back(r);
`endif
  endtask

  // Latch + ALU model: result valid ALU_LAT cycles after the save_b_n strobe edge.
  logic [3:0] mod_a, mod_b, mod_op;
  initial begin
    alu_result = 8'h00;
    mod_a = 0; mod_b = 0; mod_op = 0;
    forever begin
      @(posedge clk); #1;
      if (save_a_n === 1'b0) begin
        mod_a  = data_bus;
        mod_op = ena;
      end
      if (save_b_n === 1'b0) begin
        mod_b      = data_bus;
        alu_result = ~alu_fn(mod_a, mod_b, mod_op);
        for (int k = 1; k < ALU_LAT; k++) begin @(posedge clk); #1; end
        alu_result = alu_fn(mod_a, mod_b, mod_op);
      end
    end
  end

  // UART model: busy rises right after a request and stays up busy_len cycles.
  int         busy_len = 10;
  bit         ack_mode = 1'b1;
  bit         ext_busy = 1'b0;
  int         busy_cnt = 0;
  logic [7:0] tx_q[$];
  int         tx_first_cyc = -1;
  int         viol = 0;
  int         done_cnt = 0;
  logic       bsy_edge;
  initial begin
    uartbusy = 1'b0;
    forever begin
      @(posedge clk);
      bsy_edge = uartbusy;
      #1;
      if (done === 1'b1) done_cnt++;
      if (uart_tx_en === 1'b1) begin
        tx_q.push_back(uart_tx_data);
        if (tx_first_cyc < 0) tx_first_cyc = cyc;
        if (bsy_edge) viol++;
        if (ack_mode) busy_cnt = busy_len;
      end
      uartbusy = ext_busy || (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int start_cyc;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    op_a = a; op_b = b; op_sel = op;
    start = 1'b1;
    step();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      step();
    end
  endtask

  task automatic wait_busy(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (uartbusy) begin seen = 1'b1; break; end
      step();
    end
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] r);
    build_exp(r);
    chk({tag, " tx count"}, tx_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < tx_q.size()) chk($sformatf("%s byte%0d", tag, i), tx_q[i], exp_q[i]);
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] op, input bit exp_err, input logic [7:0] exp_res);
    int  d0;
    bit  seen;
    logic strobes, busy_seen;
    tx_q.delete();
    tx_first_cyc = -1;
    d0 = done_cnt;
    launch(a, b, op);
    chk({tag, " err"}, err, exp_err);
    if (exp_err) begin
      strobes = 1'b1;
      busy_seen = seq_busy;
      for (int i = 0; i < 4; i++) begin
        strobes   = strobes & save_a_n & save_b_n;
        busy_seen = busy_seen | seq_busy;
        step();
      end
      chk({tag, " bad-op strobes"}, strobes, 1'b1);
      chk({tag, " bad-op seq_busy"}, busy_seen, 1'b0);
      chk({tag, " bad-op tx count"}, tx_q.size(), 0);
      return;
    end
    chk({tag, " seq_busy"}, seq_busy, 1'b1);
    step();
    chk({tag, " load_a strobes"}, {save_a_n, save_b_n}, 2'b01);
    chk({tag, " load_a bus"}, data_bus, a);
    chk({tag, " ena"}, ena, op);
    step();
    chk({tag, " load_b strobes"}, {save_a_n, save_b_n}, 2'b10);
    chk({tag, " load_b bus"}, data_bus, b);
    wait_done(4000, seen);
    chk({tag, " done seen"}, seen, 1'b1);
    step();
    chk({tag, " done width"}, done, 1'b0);
    chk({tag, " idle"}, seq_busy, 1'b0);
    chk({tag, " done count"}, done_cnt - d0, 1);
    chk({tag, " tx latency"}, tx_first_cyc - start_cyc, 5);
    check_bytes(tag, exp_res);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    bit         err;
    logic [7:0] res;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int   d0;
    bit   seen;
    logic [3:0] ra, rb, rop;

    vecs[0] = '{4'h3, 4'h5, 4'b0001, 1'b0, 8'h08};
    vecs[1] = '{4'h7, 4'h2, 4'b0010, 1'b0, 8'h05};
    vecs[2] = '{4'h4, 4'h6, 4'b0100, 1'b0, 8'h18};
    vecs[3] = '{4'hA, 4'h8, 4'b1000, 1'b0, 8'hA8};
    vecs[4] = '{4'h1, 4'h1, 4'b0011, 1'b1, 8'h00};
    vecs[5] = '{4'hF, 4'hF, 4'b0001, 1'b0, 8'h1E};
    vecs[6] = '{4'h0, 4'h1, 4'b0010, 1'b0, 8'hFF};
    vecs[7] = '{4'h2, 4'h2, 4'b0000, 1'b1, 8'h00};
    vecs[8] = '{4'hF, 4'hF, 4'b0100, 1'b0, 8'hE1};
    vecs[9] = '{4'h5, 4'hC, 4'b1100, 1'b1, 8'h00};

    reset_n = 1'b0; start = 1'b0; op_a = 0; op_b = 0; op_sel = 0;
    repeat (3) step();
    chk("reset strobes", {save_a_n, save_b_n}, 2'b11);
    chk("reset ena/bus", {ena, data_bus}, 8'h00);
    chk("reset tx", {uart_tx_en, uart_tx_data}, 9'h000);
    chk("reset flags", {done, err, seq_busy}, 3'b000);
    reset_n = 1'b1;
    step();

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].err, vecs[i].res);

    for (int i = 0; i < 24; i++) begin
      ra  = 4'($urandom_range(15));
      rb  = 4'($urandom_range(15));
      rop = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'(1 << $urandom_range(3));
      busy_len = $urandom_range(1, 12);
      run_op($sformatf("rand%0d", i), ra, rb, rop, $countones(rop) != 1, alu_fn(ra, rb, rop));
    end
    busy_len = 10;

    // Busy never acknowledged: err exactly BUSY_TIMEOUT cycles after the request.
    ack_mode = 1'b0;
    tx_q.delete();
    tx_first_cyc = -1;
    d0 = done_cnt;
    launch(4'h6, 4'h3, 4'b0001);
    for (int i = 0; i < 20; i++) begin
      if (tx_first_cyc >= 0) break;
      step();
    end
    chk("timeout request seen", tx_first_cyc >= 0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < BUSY_TIMEOUT + 50; i++) begin
      if (err === 1'b1) begin seen = 1'b1; break; end
      step();
    end
    chk("timeout err seen", seen, 1'b1);
    chk("timeout delay", cyc - tx_first_cyc, BUSY_TIMEOUT);
    step();
    chk("timeout idle", seq_busy, 1'b0);
    chk("timeout no done", done_cnt - d0, 0);
    chk("timeout tx count", tx_q.size(), 1);
    ack_mode = 1'b1;
    run_op("after timeout", 4'h3, 4'h5, 4'b0001, 1'b0, 8'h08);

    // Second start while waiting on the UART is ignored.
    tx_q.delete();
    d0 = done_cnt;
    launch(4'h3, 4'h5, 4'b0001);
    wait_busy(20, seen);
    chk("ignore busy seen", seen, 1'b1);
    step();
    launch(4'h9, 4'h9, 4'b0100);
    wait_done(4000, seen);
    chk("ignore done seen", seen, 1'b1);
    repeat (10) step();
    chk("ignore done count", done_cnt - d0, 1);
    chk("ignore idle", seq_busy, 1'b0);
    check_bytes("ignore", 8'h08);

    // Reset while waiting on the UART aborts the operation.
    tx_q.delete();
    d0 = done_cnt;
    launch(4'h2, 4'h7, 4'b1000);
    wait_busy(20, seen);
    chk("abort busy seen", seen, 1'b1);
    step();
    reset_n = 1'b0;
    step();
    chk("abort strobes", {save_a_n, save_b_n}, 2'b11);
    chk("abort ena/bus", {ena, data_bus}, 8'h00);
    chk("abort tx", {uart_tx_en, uart_tx_data}, 9'h000);
    chk("abort flags", {done, err, seq_busy}, 3'b000);
    reset_n = 1'b1;
    repeat (30) step();
    chk("abort tx count", tx_q.size(), 1);
    chk("abort no done", done_cnt - d0, 0);
    chk("abort idle", seq_busy, 1'b0);

    // UART already busy: request held off until busy falls.
    ext_busy = 1'b1;
    step();
    tx_q.delete();
    launch(4'h5, 4'h4, 4'b0010);
    repeat (10) step();
    chk("held tx count", tx_q.size(), 0);
    chk("held seq_busy", seq_busy, 1'b1);
    ext_busy = 1'b0;
    wait_done(4000, seen);
    chk("held done seen", seen, 1'b1);
    check_bytes("held", 8'h01);

    chk("tx while busy", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
